sb_axil_m_bridge: RTL and testbench

SB_AXIL_M_BRIDGE -- requirements
Module: sb_axil_m_bridge

---
 rtl/sb_axil_m_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_sb_axil_m_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_axil_m_bridge.sv
// sb_axil_m_bridge: stream-to-AXI-lite master bridge.
// Requests arrive as one packed word {we, prot, addr, strb, wdata}. Each one is
// issued as a single AW+W or AR transaction. Completed B/R beats are returned as
// one packed word {is_write, resp, rdata}. Reads and writes are never in flight
// together, so responses leave the bridge in request order.
module sb_axil_m_bridge #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 16,
   parameter int STRB_WIDTH      = DATA_WIDTH/8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ERR_WIDTH       = 16
) (
   input  logic                                         clk,
   input  logic                                         reset,
   // request stream
   input  logic [4+ADDR_WIDTH+STRB_WIDTH+DATA_WIDTH-1:0] req_data,
   input  logic                                         req_valid,
   output logic                                         req_ready,
   // response stream
   output logic [DATA_WIDTH+2:0]                        resp_data,
   output logic                                         resp_valid,
   input  logic                                         resp_ready,
   // AXI-lite write address
   output logic [ADDR_WIDTH-1:0]                        m_axil_awaddr,
   output logic [2:0]                                   m_axil_awprot,
   output logic                                         m_axil_awvalid,
   input  logic                                         m_axil_awready,
   // AXI-lite write data
   output logic [DATA_WIDTH-1:0]                        m_axil_wdata,
   output logic [STRB_WIDTH-1:0]                        m_axil_wstrb,
   output logic                                         m_axil_wvalid,
   input  logic                                         m_axil_wready,
   // AXI-lite write response
   input  logic [1:0]                                   m_axil_bresp,
   input  logic                                         m_axil_bvalid,
   output logic                                         m_axil_bready,
   // AXI-lite read address
   output logic [ADDR_WIDTH-1:0]                        m_axil_araddr,
   output logic [2:0]                                   m_axil_arprot,
   output logic                                         m_axil_arvalid,
   input  logic                                         m_axil_arready,
   // AXI-lite read data
   input  logic [DATA_WIDTH-1:0]                        m_axil_rdata,
   input  logic [1:0]                                   m_axil_rresp,
   input  logic                                         m_axil_rvalid,
   output logic                                         m_axil_rready,
   // status
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]         outstanding,
   output logic [ERR_WIDTH-1:0]                         err_count
);

   localparam int REQ_W = 4 + ADDR_WIDTH + STRB_WIDTH + DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

   // Type of the transactions currently in flight; IDLE only when none are.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [CNT_W-1:0]        r_outstanding;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic [ERR_WIDTH-1:0]    r_err_count;

   logic                    r_awvalid;
   logic                    r_wvalid;
   logic                    r_arvalid;
   logic [ADDR_WIDTH-1:0]   r_awaddr;
   logic [2:0]              r_awprot;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_WIDTH-1:0]   r_wstrb;
   logic [ADDR_WIDTH-1:0]   r_araddr;
   logic [2:0]              r_arprot;

   logic                    r_resp_valid;
   logic [DATA_WIDTH+2:0]   r_resp_data;

   // request field decode
   logic                    w_req_we;
   logic [2:0]              w_req_prot;
   logic [ADDR_WIDTH-1:0]   w_req_addr;
   logic [STRB_WIDTH-1:0]   w_req_strb;
   logic [DATA_WIDTH-1:0]   w_req_wdata;

   logic                    w_issue_busy;
   logic                    w_type_ok;
   logic                    w_req_ready;
   logic                    w_accept;
   logic                    w_resp_slot;
   logic                    w_bready;
   logic                    w_rready;
   logic                    w_b_hs;
   logic                    w_r_hs;
   logic                    w_done;
   logic                    w_err_hit;

   assign w_req_we    = req_data[REQ_W-1];
   assign w_req_prot  = req_data[REQ_W-2 -: 3];
   assign w_req_addr  = req_data[STRB_WIDTH+DATA_WIDTH +: ADDR_WIDTH];
   assign w_req_strb  = req_data[DATA_WIDTH +: STRB_WIDTH];
   assign w_req_wdata = req_data[DATA_WIDTH-1:0];

   // A new request must wait for the previous address/data issue to finish,
   // for a free slot, and for the pipe to drain when the direction changes.
   assign w_issue_busy = r_awvalid | r_wvalid | r_arvalid;
   assign w_type_ok    = (r_outstanding == '0) ||
                         (w_req_we ? (r_state == ST_WRITE) : (r_state == ST_READ));
   assign w_req_ready  = !reset && !w_issue_busy && (r_outstanding < MAX_OUT) && w_type_ok;
   assign w_accept     = req_valid && w_req_ready;

   // B/R are only taken when the response register can accept the beat.
   assign w_resp_slot  = !r_resp_valid || resp_ready;
   assign w_bready     = !reset && (r_state == ST_WRITE) && (r_outstanding != '0) && w_resp_slot;
   assign w_rready     = !reset && (r_state == ST_READ)  && (r_outstanding != '0) && w_resp_slot;
   assign w_b_hs       = m_axil_bvalid && w_bready;
   assign w_r_hs       = m_axil_rvalid && w_rready;
   assign w_done       = w_b_hs || w_r_hs;
   assign w_err_hit    = (w_b_hs && (m_axil_bresp != 2'b00)) ||
                         (w_r_hs && (m_axil_rresp != 2'b00));

   // In-flight count: accept and retire in the same cycle cancel out.
   always_comb begin
      w_cnt_nxt = r_outstanding;
      case ({w_accept, w_done})
         2'b10:   w_cnt_nxt = r_outstanding + CNT_W'(1);
         2'b01:   w_cnt_nxt = r_outstanding - CNT_W'(1);
         default: w_cnt_nxt = r_outstanding;
      endcase
   end

   // Direction tracking: set by the first accepted request, cleared on drain.
   always_comb begin
      w_state_nxt = r_state;
      if (w_cnt_nxt == '0)
         w_state_nxt = ST_IDLE;
      else if (w_accept)
         w_state_nxt = w_req_we ? ST_WRITE : ST_READ;
   end

   // State and in-flight counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_outstanding <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_outstanding <= w_cnt_nxt;
      end
   end

   // Write issue: AW and W are raised together and retire independently.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_awaddr  <= '0;
         r_awprot  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else if (w_accept && w_req_we) begin
         r_awvalid <= 1'b1;
         r_wvalid  <= 1'b1;
         r_awaddr  <= w_req_addr;
         r_awprot  <= w_req_prot;
         r_wdata   <= w_req_wdata;
         r_wstrb   <= w_req_strb;
      end else begin
         if (r_awvalid && m_axil_awready) r_awvalid <= 1'b0;
         if (r_wvalid  && m_axil_wready)  r_wvalid  <= 1'b0;
      end
   end

   // Read issue: AR held until its handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_arvalid <= 1'b0;
         r_araddr  <= '0;
         r_arprot  <= '0;
      end else if (w_accept && !w_req_we) begin
         r_arvalid <= 1'b1;
         r_araddr  <= w_req_addr;
         r_arprot  <= w_req_prot;
      end else if (r_arvalid && m_axil_arready) begin
         r_arvalid <= 1'b0;
      end
   end

   // Response register: loads on B/R handshake, drains on resp_ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
      end else if (w_b_hs) begin
         r_resp_valid <= 1'b1;
         r_resp_data  <= {1'b1, m_axil_bresp, {DATA_WIDTH{1'b0}}};
      end else if (w_r_hs) begin
         r_resp_valid <= 1'b1;
         r_resp_data  <= {1'b0, m_axil_rresp, m_axil_rdata};
      end else if (resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end

   // Saturating count of non-OKAY responses.
   always_ff @(posedge clk) begin
      if (reset)
         r_err_count <= '0;
      else if (w_err_hit && (r_err_count != '1))
         r_err_count <= r_err_count + ERR_WIDTH'(1);
   end

   assign req_ready      = w_req_ready;
   assign resp_valid     = r_resp_valid;
   assign resp_data      = r_resp_data;
   assign m_axil_awaddr  = r_awaddr;
   assign m_axil_awprot  = r_awprot;
   assign m_axil_awvalid = r_awvalid;
   assign m_axil_wdata   = r_wdata;
   assign m_axil_wstrb   = r_wstrb;
   assign m_axil_wvalid  = r_wvalid;
   assign m_axil_bready  = w_bready;
   assign m_axil_araddr  = r_araddr;
   assign m_axil_arprot  = r_arprot;
   assign m_axil_arvalid = r_arvalid;
   assign m_axil_rready  = w_rready;
   assign outstanding    = r_outstanding;
   assign err_count      = r_err_count;

endmodule

// File: tb/tb_sb_axil_m_bridge.sv
// Directed bench for sb_axil_m_bridge (default parameters: 32-bit data,
// 16-bit address, 4 outstanding). The AXI-lite slave is driven by hand.
module tb_sb_axil_m_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [55:0] req_data;
   logic        req_valid;
   logic        req_ready;
   logic [34:0] resp_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [15:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;
   logic [2:0]  outstanding;
   logic [15:0] err_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sb_axil_m_bridge dut (
      .clk(clk), .reset(reset),
      .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
      .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
      .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
      .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
      .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
      .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
      .outstanding(outstanding), .err_count(err_count)
   );

   function automatic logic [55:0] mk_req(input logic we, input logic [2:0] prot,
                                          input logic [15:0] addr, input logic [3:0] strb,
                                          input logic [31:0] wd);
      return {we, prot, addr, strb, wd};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; req_data = '0; req_valid = 1'b0; resp_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
      arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;

      // ---- reset state ----
      tick(); tick();
      check("rst_req_ready",   64'(req_ready), 64'd0);
      check("rst_awvalid",     64'(awvalid), 64'd0);
      check("rst_wvalid",      64'(wvalid), 64'd0);
      check("rst_arvalid",     64'(arvalid), 64'd0);
      check("rst_resp_valid",  64'(resp_valid), 64'd0);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_err_count",   64'(err_count), 64'd0);
      reset = 1'b0;
      #1;
      check("post_rst_req_ready", 64'(req_ready), 64'd1);

      // ---- stray B/R with nothing in flight is ignored ----
      bvalid = 1'b1; rvalid = 1'b1; bresp = 2'b10; rresp = 2'b10;
      #1;
      check("stray_bready", 64'(bready), 64'd0);
      check("stray_rready", 64'(rready), 64'd0);
      tick();
      bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00;
      check("stray_resp_valid",  64'(resp_valid), 64'd0);
      check("stray_err_count",   64'(err_count), 64'd0);
      check("stray_outstanding", 64'(outstanding), 64'd0);

      // ---- single write, AW/W ready immediately ----
      req_data = mk_req(1'b1, 3'd0, 16'h0010, 4'hF, 32'hDEADBEEF);
      req_valid = 1'b1; awready = 1'b1; wready = 1'b1;
      #1;
      check("w1_req_ready", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      check("w1_awvalid", 64'(awvalid), 64'd1);
      check("w1_wvalid",  64'(wvalid), 64'd1);
      check("w1_awaddr",  64'(awaddr), 64'h10);
      check("w1_wdata",   64'(wdata), 64'hDEADBEEF);
      check("w1_wstrb",   64'(wstrb), 64'hF);
      check("w1_out1",    64'(outstanding), 64'd1);
      tick();
      awready = 1'b0; wready = 1'b0;
      check("w1_awvalid_drop", 64'(awvalid), 64'd0);
      check("w1_wvalid_drop",  64'(wvalid), 64'd0);
      tick();
      bvalid = 1'b1; bresp = 2'b00;
      #1;
      check("w1_bready", 64'(bready), 64'd1);
      tick();
      bvalid = 1'b0;
      check("w1_resp_valid", 64'(resp_valid), 64'd1);
      check("w1_resp_data",  64'(resp_data), 64'({1'b1, 2'b00, 32'h0}));
      check("w1_out0",       64'(outstanding), 64'd0);
      resp_ready = 1'b1;
      tick();
      check("w1_resp_drain", 64'(resp_valid), 64'd0);

      // ---- write with W completing 5 cycles after AW ----
      req_data = mk_req(1'b1, 3'b010, 16'h0020, 4'h3, 32'h12345678);
      req_valid = 1'b1; awready = 1'b1; wready = 1'b0;
      tick();
      req_valid = 1'b0;
      check("w2_awvalid", 64'(awvalid), 64'd1);
      check("w2_awprot",  64'(awprot), 64'd2);
      tick();
      awready = 1'b0;
      check("w2_aw_drop",  64'(awvalid), 64'd0);
      check("w2_w_hold",   64'(wvalid), 64'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("w2_w_stall_valid", 64'(wvalid), 64'd1);
         check("w2_w_stall_data",  64'(wdata), 64'h12345678);
         check("w2_w_stall_strb",  64'(wstrb), 64'h3);
      end
      wready = 1'b1;
      tick();
      wready = 1'b0;
      check("w2_w_drop", 64'(wvalid), 64'd0);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      check("w2_resp_valid", 64'(resp_valid), 64'd1);
      check("w2_resp_data",  64'(resp_data), 64'({1'b1, 2'b00, 32'h0}));
      tick();
      check("w2_resp_once", 64'(resp_valid), 64'd0);
      check("w2_out0",      64'(outstanding), 64'd0);
      tick();
      check("w2_no_extra", 64'(resp_valid), 64'd0);

      // ---- four reads fill the window, then return in order ----
      arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_data = mk_req(1'b0, 3'd0, 16'(16'h0100 + i), 4'h0, 32'h0);
         req_valid = 1'b1;
         #1;
         check("r4_req_ready", 64'(req_ready), 64'd1);
         tick();
         req_valid = 1'b0;
         check("r4_arvalid", 64'(arvalid), 64'd1);
         check("r4_araddr",  64'(araddr), 64'(16'h0100 + i));
         tick();
         check("r4_ar_drop", 64'(arvalid), 64'd0);
      end
      check("r4_out_full", 64'(outstanding), 64'd4);
      req_data = mk_req(1'b0, 3'd0, 16'h0200, 4'h0, 32'h0);
      req_valid = 1'b1;
      #1;
      check("r4_full_stall", 64'(req_ready), 64'd0);
      req_valid = 1'b0;
      rvalid = 1'b1; rresp = 2'b00;
      for (int i = 0; i < 4; i++) begin
         rdata = 32'(i + 1);
         #1;
         check("r4_rready", 64'(rready), 64'd1);
         tick();
         check("r4_resp_valid", 64'(resp_valid), 64'd1);
         check("r4_resp_data",  64'(resp_data), 64'(i + 1));
         check("r4_out_dec",    64'(outstanding), 64'(3 - i));
      end
      rvalid = 1'b0;
      tick();
      check("r4_resp_drain", 64'(resp_valid), 64'd0);
      check("r4_out0",       64'(outstanding), 64'd0);

      // ---- read queued behind two writes ----
      awready = 1'b1; wready = 1'b1;
      req_data = mk_req(1'b1, 3'd0, 16'h0040, 4'hF, 32'h11111111);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      req_data = mk_req(1'b1, 3'd0, 16'h0044, 4'hF, 32'h22222222);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      check("rw_out2", 64'(outstanding), 64'd2);
      req_data = mk_req(1'b0, 3'd0, 16'h0080, 4'h0, 32'h0);
      req_valid = 1'b1;
      #1;
      check("rw_stall_2", 64'(req_ready), 64'd0);
      bvalid = 1'b1; bresp = 2'b00;
      tick();
      check("rw_out1", 64'(outstanding), 64'd1);
      check("rw_no_ar_early", 64'(arvalid), 64'd0);
      #1;
      check("rw_stall_1", 64'(req_ready), 64'd0);
      tick();
      bvalid = 1'b0;
      check("rw_out0", 64'(outstanding), 64'd0);
      check("rw_no_ar_yet", 64'(arvalid), 64'd0);
      #1;
      check("rw_ready_again", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      check("rw_arvalid", 64'(arvalid), 64'd1);
      check("rw_araddr",  64'(araddr), 64'h80);
      tick();
      rvalid = 1'b1; rdata = 32'hCAFE0001; rresp = 2'b00;
      tick();
      rvalid = 1'b0;
      check("rw_resp_data", 64'(resp_data), 64'({1'b0, 2'b00, 32'hCAFE0001}));
      tick();
      check("rw_out_end", 64'(outstanding), 64'd0);

      // ---- response back-pressure and error counting ----
      resp_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_data = mk_req(1'b0, 3'd0, 16'(16'h0200 + 4 * i), 4'h0, 32'h0);
         req_valid = 1'b1;
         tick();
         req_valid = 1'b0;
         tick();
      end
      check("bp_out2", 64'(outstanding), 64'd2);
      rvalid = 1'b1; rresp = 2'b10; rdata = 32'h000000AA;
      #1;
      check("bp_rready_first", 64'(rready), 64'd1);
      tick();
      check("bp_resp_valid", 64'(resp_valid), 64'd1);
      check("bp_err1",       64'(err_count), 64'd1);
      check("bp_resp_first", 64'(resp_data), 64'({1'b0, 2'b10, 32'h000000AA}));
      rdata = 32'h000000BB;
      #1;
      check("bp_rready_blocked", 64'(rready), 64'd0);
      tick();
      check("bp_resp_stable", 64'(resp_data), 64'({1'b0, 2'b10, 32'h000000AA}));
      check("bp_out_hold",    64'(outstanding), 64'd1);
      check("bp_err_hold",    64'(err_count), 64'd1);
      resp_ready = 1'b1;
      #1;
      check("bp_rready_open", 64'(rready), 64'd1);
      tick();
      rvalid = 1'b0; rresp = 2'b00;
      check("bp_resp_second", 64'(resp_data), 64'({1'b0, 2'b10, 32'h000000BB}));
      check("bp_err2",        64'(err_count), 64'd2);
      tick();
      check("bp_drain", 64'(resp_valid), 64'd0);
      check("bp_out0",  64'(outstanding), 64'd0);

      // ---- reset in the middle of a write ----
      awready = 1'b1; wready = 1'b1;
      req_data = mk_req(1'b1, 3'd0, 16'h0300, 4'hF, 32'h33333333);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      awready = 1'b0; wready = 1'b0;
      req_data = mk_req(1'b1, 3'd0, 16'h0304, 4'hF, 32'h44444444);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("mr_awvalid_pend", 64'(awvalid), 64'd1);
      check("mr_out2",         64'(outstanding), 64'd2);
      reset = 1'b1;
      tick();
      check("mr_awvalid",    64'(awvalid), 64'd0);
      check("mr_wvalid",     64'(wvalid), 64'd0);
      check("mr_arvalid",    64'(arvalid), 64'd0);
      check("mr_resp_valid", 64'(resp_valid), 64'd0);
      check("mr_outstanding",64'(outstanding), 64'd0);
      check("mr_err_count",  64'(err_count), 64'd0);
      check("mr_awaddr",     64'(awaddr), 64'd0);
      check("mr_wdata",      64'(wdata), 64'd0);
      check("mr_req_ready",  64'(req_ready), 64'd0);
      check("mr_bready",     64'(bready), 64'd0);
      reset = 1'b0;
      #1;
      check("mr_ready_after", 64'(req_ready), 64'd1);
      tick();
      check("mr_ready_cycle", 64'(req_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
